dds_word_sequencer: RTL and testbench

//  Parametrised DDS control-word generator for ECT multi-frequency excitation; replaces the fixed 200 kHz word source.

---
 rtl/dds_word_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_dds_word_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_word_sequencer.sv
`default_nettype none
// ============================================================================
// dds_word_sequencer : DDS control-word generator (fixed / hop / sweep)
// Revision: 1.0
// ============================================================================
module dds_word_sequencer #(
  parameter int NUM_FREQ = 4,
  parameter int PW = 32,
  parameter int PHW = 16,
  parameter int DW = 16,
  parameter logic [PW-1:0] DEFAULT_INC = 85899346,
  localparam int IW = $clog2(NUM_FREQ)
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           WrEn,
  input  logic [IW-1:0]  WrAddr,
  input  logic [PW-1:0]  WrData,
  input  logic [1:0]     Mode,
  input  logic [IW-1:0]  SelIdx,
  input  logic [DW-1:0]  DwellCycles,
  input  logic [PW-1:0]  SweepStart,
  input  logic [PW-1:0]  SweepStep,
  input  logic [PW-1:0]  SweepStop,
  input  logic [PW-1:0]  FreqModIn,
  input  logic [PHW-1:0] PhaseModIn,
  input  logic           Start,
  input  logic           Stop,
  output logic [PW-1:0]  PhaseInc,
  output logic [PW-1:0]  FreqMod,
  output logic [PHW-1:0] PhaseMod,
  output logic           Update,
  output logic [IW-1:0]  FreqIdx,
  output logic           Wrap,
  output logic           Busy
);

  localparam logic [IW:0]   c_numFreq = (IW+1)'(NUM_FREQ);
  localparam logic [IW-1:0] c_lastIdx = IW'(NUM_FREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state, w_nextState;

  logic [PW-1:0]  r_table [NUM_FREQ];
  logic [1:0]     r_mode;
  logic [IW-1:0]  r_selIdx;
  logic [DW-1:0]  r_dwellCfg;
  logic [DW-1:0]  r_dwellCnt;
  logic [PW-1:0]  r_sweepStart, r_sweepStep, r_sweepStop;
  logic [PW-1:0]  r_freqModL;
  logic [PHW-1:0] r_phaseModL;
  logic [PW-1:0]  r_phaseInc, r_freqMod;
  logic [PHW-1:0] r_phaseMod;
  logic [IW-1:0]  r_freqIdx;
  logic           r_update, r_wrap;

  logic           w_start, w_load, w_step;
  logic           w_isHop, w_isSweep, w_isFixed;
  logic           w_wrInRange;
  logic [IW-1:0]  w_selSafe;
  logic [DW-1:0]  w_dwellLast;
  logic           w_dwellDone;
  logic [IW-1:0]  w_hopIdx;
  logic [PW:0]    w_sweepSum;
  logic           w_sweepWrap;

  assign w_isHop     = (r_mode == 2'b01);
  assign w_isSweep   = (r_mode == 2'b10);
  assign w_isFixed   = !w_isHop && !w_isSweep;
  assign w_wrInRange = ({1'b0, WrAddr} < c_numFreq);
  // An out-of-range selection falls back to entry 0 rather than reading past the table
  assign w_selSafe   = ({1'b0, r_selIdx} < c_numFreq) ? r_selIdx : '0;
  assign w_dwellLast = (r_dwellCfg == '0) ? '0 : r_dwellCfg - 1'b1;
  assign w_dwellDone = (r_dwellCnt == w_dwellLast);
  assign w_hopIdx    = (r_freqIdx == c_lastIdx) ? '0 : r_freqIdx + 1'b1;
  assign w_sweepSum  = {1'b0, r_phaseInc} + {1'b0, r_sweepStep};
  assign w_sweepWrap = w_sweepSum[PW] || (w_sweepSum[PW-1:0] > r_sweepStop);

  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Stop has priority over Start and over dwell expiry
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start && !Stop) begin
          w_start     = 1'b1;
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        if (Stop) begin
          w_nextState = S_IDLE;
        end else begin
          w_load      = 1'b1;
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (Stop)                         w_nextState = S_IDLE;
        else if (!w_isFixed && w_dwellDone) w_step    = 1'b1;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_FREQ; i++) r_table[i] <= DEFAULT_INC;
      r_mode       <= '0;
      r_selIdx     <= '0;
      r_dwellCfg   <= '0;
      r_dwellCnt   <= '0;
      r_sweepStart <= '0;
      r_sweepStep  <= '0;
      r_sweepStop  <= '0;
      r_freqModL   <= '0;
      r_phaseModL  <= '0;
      r_phaseInc   <= DEFAULT_INC;
      r_freqMod    <= '0;
      r_phaseMod   <= '0;
      r_freqIdx    <= '0;
      r_update     <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_wrap   <= 1'b0;
      if (WrEn && w_wrInRange) r_table[WrAddr] <= WrData;
      if (w_start) begin
        r_mode       <= Mode;
        r_selIdx     <= SelIdx;
        r_dwellCfg   <= DwellCycles;
        r_sweepStart <= SweepStart;
        r_sweepStep  <= SweepStep;
        r_sweepStop  <= SweepStop;
        r_freqModL   <= FreqModIn;
        r_phaseModL  <= PhaseModIn;
      end
      if (w_load) begin
        r_dwellCnt <= '0;
        r_update   <= 1'b1;
        r_freqMod  <= r_freqModL;
        r_phaseMod <= r_phaseModL;
        if (w_isSweep) begin
          r_phaseInc <= r_sweepStart;
          r_freqIdx  <= '0;
        end else if (w_isHop) begin
          r_phaseInc <= r_table[0];
          r_freqIdx  <= '0;
        end else begin
          r_phaseInc <= r_table[w_selSafe];
          r_freqIdx  <= w_selSafe;
        end
      end else if (r_state == S_RUN && !Stop) begin
        r_dwellCnt <= w_dwellDone ? '0 : r_dwellCnt + 1'b1;
        if (w_step) begin
          r_update <= 1'b1;
          if (w_isHop) begin
            r_freqIdx  <= w_hopIdx;
            r_phaseInc <= r_table[w_hopIdx];
            r_wrap     <= (w_hopIdx == '0);
          end else begin
            r_phaseInc <= w_sweepWrap ? r_sweepStart : w_sweepSum[PW-1:0];
            r_wrap     <= w_sweepWrap;
          end
        end
      end
    end
  end

  assign PhaseInc = r_phaseInc;
  assign FreqMod  = r_freqMod;
  assign PhaseMod = r_phaseMod;
  assign Update   = r_update;
  assign FreqIdx  = r_freqIdx;
  assign Wrap     = r_wrap;
  assign Busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dds_word_sequencer.sv
`default_nettype none
// Bench for dds_word_sequencer: expected update words are queued at start and matched on each Update.
module tb_dds_word_sequencer;

  localparam logic [31:0] DEF = 32'd85899346;

  logic        clk = 1'b0;
  logic        rstN;
  logic        wrEn;
  logic [1:0]  wrAddr;
  logic [31:0] wrData;
  logic [1:0]  mode, selIdx;
  logic [15:0] dwell;
  logic [31:0] swStart, swStep, swStop, fmIn;
  logic [15:0] pmIn;
  logic        start, stop;

  logic [31:0] phaseInc, freqMod;
  logic [15:0] phaseMod;
  logic        update, wrap, busy;
  logic [1:0]  freqIdx;

  logic [31:0] d3PhaseInc, d3FreqMod;
  logic [15:0] d3PhaseMod;
  logic        d3Update, d3Wrap, d3Busy;
  logic [1:0]  d3FreqIdx;

  dds_word_sequencer dut (
    .Clk(clk), .Rst_n(rstN), .WrEn(wrEn), .WrAddr(wrAddr), .WrData(wrData),
    .Mode(mode), .SelIdx(selIdx), .DwellCycles(dwell),
    .SweepStart(swStart), .SweepStep(swStep), .SweepStop(swStop),
    .FreqModIn(fmIn), .PhaseModIn(pmIn), .Start(start), .Stop(stop),
    .PhaseInc(phaseInc), .FreqMod(freqMod), .PhaseMod(phaseMod),
    .Update(update), .FreqIdx(freqIdx), .Wrap(wrap), .Busy(busy)
  );

  dds_word_sequencer #(.NUM_FREQ(3)) dut3 (
    .Clk(clk), .Rst_n(rstN), .WrEn(wrEn), .WrAddr(wrAddr), .WrData(wrData),
    .Mode(mode), .SelIdx(selIdx), .DwellCycles(dwell),
    .SweepStart(swStart), .SweepStep(swStep), .SweepStop(swStop),
    .FreqModIn(fmIn), .PhaseModIn(pmIn), .Start(start), .Stop(stop),
    .PhaseInc(d3PhaseInc), .FreqMod(d3FreqMod), .PhaseMod(d3PhaseMod),
    .Update(d3Update), .FreqIdx(d3FreqIdx), .Wrap(d3Wrap), .Busy(d3Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] inc;
    logic [1:0]  idx;
    logic        wrap;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] tbl [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every Update must match the oldest queued expectation at its cycle
  always @(negedge clk) begin
    if (update === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update cyc=%0d actual inc=%0d idx=%0d required no update",
                 cyc, phaseInc, freqIdx);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || phaseInc !== e.inc || freqIdx !== e.idx || wrap !== e.wrap) begin
          errors++;
          $display("FAIL update_word actual cyc=%0d inc=%0d idx=%0d wrap=%0b required cyc=%0d inc=%0d idx=%0d wrap=%0b",
                   cyc, phaseInc, freqIdx, wrap, e.cyc, e.inc, e.idx, e.wrap);
        end
      end
    end else begin
      if (wrap === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL wrap_without_update cyc=%0d actual wrap=1 required 0", cyc);
      end
      if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_update cyc=%0d actual none required inc=%0d at cyc=%0d",
                 cyc, sb[0].inc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic push(input int c, input logic [31:0] inc, input logic [1:0] idx, input logic w);
    exp_t x;
    x.cyc = c; x.inc = inc; x.idx = idx; x.wrap = w;
    sb.push_back(x);
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wrEn = 1'b1; wrAddr = a; wrData = d;
    @(negedge clk);
    wrEn = 1'b0;
    tbl[a] = d;
  endtask

  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic stop_at(input int edgeNum);
    wait_cyc(edgeNum - 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 5;
      if (phaseInc !== DEF) begin errors++; $display("FAIL reset_phaseinc actual=%0d required=%0d", phaseInc, DEF); end
      if (freqMod !== 32'd0) begin errors++; $display("FAIL reset_freqmod actual=%0d required=0", freqMod); end
      if (phaseMod !== 16'd0) begin errors++; $display("FAIL reset_phasemod actual=%0h required=0", phaseMod); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%0b required=0", busy); end
      if (update !== 1'b0) begin errors++; $display("FAIL reset_update actual=%0b required=0", update); end
    end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hop;
    int k;
    write_entry(2'd0, 32'd42949673);
    write_entry(2'd1, 32'd85899346);
    write_entry(2'd2, 32'd214748365);
    write_entry(2'd3, 32'd429496730);
    mode = 2'b01; dwell = 16'd4; fmIn = 32'd0; pmIn = 16'd0;
    pulse_start(k);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL hop_busy_load actual=%0b required=1", busy); end
    if (update !== 1'b0) begin errors++; $display("FAIL hop_update_load actual=%0b required=0", update); end
    for (int j = 0; j < 6; j++) push(k + 1 + 4*j, tbl[j%4], 2'(j%4), (j == 4));
    stop_at(k + 23);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL hop_busy_stop actual=%0b required=0", busy); end
    if (phaseInc !== tbl[1]) begin errors++; $display("FAIL hop_hold_inc actual=%0d required=%0d", phaseInc, tbl[1]); end
    if (freqIdx !== 2'd1) begin errors++; $display("FAIL hop_hold_idx actual=%0d required=1", freqIdx); end
    if (sb.size() != 0) begin errors++; $display("FAIL hop_pending actual=%0d required=0", sb.size()); end
  endtask

  task automatic test_sweep;
    int k;
    logic [31:0] seq [6];
    seq[0] = 32'd1000; seq[1] = 32'd1300; seq[2] = 32'd1600;
    seq[3] = 32'd1900; seq[4] = 32'd1000; seq[5] = 32'd1300;
    mode = 2'b10; dwell = 16'd2; swStart = 32'd1000; swStep = 32'd300; swStop = 32'd1900;
    pulse_start(k);
    for (int j = 0; j < 6; j++) push(k + 1 + 2*j, seq[j], 2'd0, (j == 4));
    stop_at(k + 12);
    checks += 2;
    if (phaseInc !== 32'd1300) begin errors++; $display("FAIL sweep_hold actual=%0d required=1300", phaseInc); end
    if (sb.size() != 0) begin errors++; $display("FAIL sweep_pending actual=%0d required=0", sb.size()); end

    dwell = 16'd3; swStart = 32'hFFFF_FF00; swStep = 32'h200; swStop = 32'hFFFF_FFFF;
    pulse_start(k);
    for (int j = 0; j < 3; j++) push(k + 1 + 3*j, 32'hFFFF_FF00, 2'd0, (j > 0));
    stop_at(k + 8);

    dwell = 16'd1; swStart = 32'd5000; swStep = 32'd10; swStop = 32'd100;
    pulse_start(k);
    for (int j = 0; j < 3; j++) push(k + 1 + j, 32'd5000, 2'd0, (j > 0));
    stop_at(k + 4);

    dwell = 16'd0; swStart = 32'd7; swStep = 32'd0; swStop = 32'd100;
    pulse_start(k);
    for (int j = 0; j < 4; j++) push(k + 1 + j, 32'd7, 2'd0, 1'b0);
    stop_at(k + 5);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sweep_edge_pending actual=%0d required=0", sb.size()); end
  endtask

  task automatic test_fixed;
    int k;
    mode = 2'b00; selIdx = 2'd2; pmIn = 16'h4000; fmIn = 32'd5;
    pulse_start(k);
    push(k + 1, 32'd214748365, 2'd2, 1'b0);
    repeat (3) @(negedge clk);
    write_entry(2'd2, 32'd123);
    selIdx = 2'd0;
    @(negedge clk); start = 1'b1; mode = 2'b01;
    @(negedge clk); start = 1'b0;
    wait_cyc(k + 20);
    checks += 5;
    if (phaseInc !== 32'd214748365) begin errors++; $display("FAIL fixed_hold_inc actual=%0d required=214748365", phaseInc); end
    if (freqMod !== 32'd5) begin errors++; $display("FAIL fixed_freqmod actual=%0d required=5", freqMod); end
    if (phaseMod !== 16'h4000) begin errors++; $display("FAIL fixed_phasemod actual=%0h required=4000", phaseMod); end
    if (freqIdx !== 2'd2) begin errors++; $display("FAIL fixed_idx actual=%0d required=2", freqIdx); end
    if (busy !== 1'b1) begin errors++; $display("FAIL fixed_busy actual=%0b required=1", busy); end
    stop_at(cyc + 2);

    mode = 2'b11; selIdx = 2'd2; fmIn = 32'd0; pmIn = 16'd0;
    pulse_start(k);
    push(k + 1, 32'd123, 2'd2, 1'b0);
    repeat (5) @(negedge clk);
    checks += 2;
    if (freqMod !== 32'd0) begin errors++; $display("FAIL fixed_relatch_fm actual=%0d required=0", freqMod); end
    if (phaseInc !== 32'd123) begin errors++; $display("FAIL fixed_new_entry actual=%0d required=123", phaseInc); end
    stop_at(cyc + 2);
  endtask

  task automatic test_back_to_back;
    int k;
    mode = 2'b01; dwell = 16'd3;
    pulse_start(k);
    push(k + 1, tbl[0], 2'd0, 1'b0);
    push(k + 4, tbl[1], 2'd1, 1'b0);
    stop_at(k + 7);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL collide_busy actual=%0b required=0", busy); end
    if (phaseInc !== tbl[1]) begin errors++; $display("FAIL collide_inc actual=%0d required=%0d", phaseInc, tbl[1]); end
    if (freqIdx !== 2'd1) begin errors++; $display("FAIL collide_idx actual=%0d required=1", freqIdx); end
    if (sb.size() != 0) begin errors++; $display("FAIL collide_pending actual=%0d required=0", sb.size()); end
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle actual=%0b required=0", busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_out_of_range;
    int k;
    logic [31:0] exp3 [3];
    write_entry(2'd0, 32'd11);
    write_entry(2'd1, 32'd22);
    write_entry(2'd2, 32'd33);
    write_entry(2'd3, 32'd44);
    exp3[0] = 32'd11; exp3[1] = 32'd22; exp3[2] = 32'd33;
    mode = 2'b01; dwell = 16'd1;
    pulse_start(k);
    for (int j = 0; j < 5; j++) push(k + 1 + j, tbl[j%4], 2'(j%4), (j == 4));
    for (int j = 0; j < 5; j++) begin
      wait_cyc(k + 1 + j);
      checks++;
      if (d3PhaseInc !== exp3[j%3] || d3FreqIdx !== 2'(j%3) || d3Update !== 1'b1)
        begin errors++; $display("FAIL depth3_hop step=%0d actual inc=%0d idx=%0d upd=%0b required inc=%0d idx=%0d upd=1",
                                  j, d3PhaseInc, d3FreqIdx, d3Update, exp3[j%3], j%3); end
    end
    stop_at(k + 6);
  endtask

  task automatic test_reset_midrun;
    int k;
    mode = 2'b01; dwell = 16'd2; fmIn = 32'd9; pmIn = 16'd3;
    pulse_start(k);
    push(k + 1, tbl[0], 2'd0, 1'b0);
    push(k + 3, tbl[1], 2'd1, 1'b0);
    wait_cyc(k + 4);
    rstN = 1'b0; wrEn = 1'b1; wrAddr = 2'd0; wrData = 32'd77; start = 1'b1;
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) tbl[i] = DEF;
    checks += 5;
    if (phaseInc !== DEF) begin errors++; $display("FAIL rst_mid_inc actual=%0d required=%0d", phaseInc, DEF); end
    if (freqMod !== 32'd0) begin errors++; $display("FAIL rst_mid_fm actual=%0d required=0", freqMod); end
    if (phaseMod !== 16'd0) begin errors++; $display("FAIL rst_mid_pm actual=%0h required=0", phaseMod); end
    if (freqIdx !== 2'd0) begin errors++; $display("FAIL rst_mid_idx actual=%0d required=0", freqIdx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy actual=%0b required=0", busy); end
    mode = 2'b00; selIdx = 2'd0; fmIn = 32'd0; pmIn = 16'd0;
    pulse_start(k);
    push(k + 1, DEF, 2'd0, 1'b0);
    stop_at(k + 4);
  endtask

  initial begin
    rstN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; mode = '0; selIdx = '0;
    dwell = '0; swStart = '0; swStep = '0; swStop = '0; fmIn = '0; pmIn = '0;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) tbl[i] = DEF;
    test_reset;
    test_hop;
    test_sweep;
    test_fixed;
    test_back_to_back;
    test_out_of_range;
    test_reset_midrun;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_pending actual=%0d required=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
